// File: rtl/tx_spart_fifo_pkg.sv
// Shared types and constants for the SPART transmit path.
// Holds the transmitter state encoding, parity modes and register addresses.
package tx_spart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] ADDR_TXDATA = 2'b00;
    localparam logic [1:0] ADDR_CTRL   = 2'b01;

    // Mode 2'b11 is deliberately treated the same as no parity.
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/tx_spart_fifo_if.sv
// Processor-bus, baud-tick and status bundle of the SPART transmitter.
// The master side is the bus/BRG; the slave side is the transmitter.
interface tx_spart_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          iocs;
    logic                          iorw;
    logic [1:0]                    ioaddr;
    logic [DATA_BITS-1:0]          databus;
    logic                          brg_full;
    logic                          txd;
    logic                          tbr;
    logic                          tx_busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;
    logic                          ovr;

    modport master (
        output iocs, iorw, ioaddr, databus, brg_full,
        input  txd, tbr, tx_busy, fifo_cnt, ovr
    );

    modport slave (
        input  iocs, iorw, ioaddr, databus, brg_full,
        output txd, tbr, tx_busy, fifo_cnt, ovr
    );
endinterface

// File: rtl/spart_fifo.sv
// Generic synchronous FIFO; head word is visible combinationally on pop_dat_o.
// Latency: push visible in count/flags one cycle later.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module spart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign cnt_o     = cnt_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok   = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/tx_spart_fifo.sv
// SPART transmitter: bus writes fill a FIFO, frames go out on txd (optional TX_BREAK_EN adds brk).
// Latency: frame start bit appears the cycle after the first baud tick that sees data.
// Backpressure: tbr drops when the FIFO is full; writes while full are dropped and set ovr.
module tx_spart_fifo
    import tx_spart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst,
`ifdef TX_BREAK_EN
    input  logic           brk,
`endif
    tx_spart_fifo_if.slave bus
);
    localparam int BCW = $clog2(DATA_BITS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state_q;
    logic [BCW-1:0]       bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [1:0]           frm_par_q;
    logic                 par_bit_q;
    logic                 txd_q;
    logic [1:0]           par_mode_q;
    logic                 ovr_q;

    logic                 wr_data;
    logic                 wr_ctrl;
    logic                 brk_act;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_cnt;
    logic [DATA_BITS-1:0] head;
    logic                 pop;
    logic                 last_stop;
    logic                 par_bit_d;
    logic                 overrun;

`ifdef TX_BREAK_EN
    assign brk_act = brk;
`else
    assign brk_act = 1'b0;
`endif

    assign wr_data   = bus.iocs && !bus.iorw && (bus.ioaddr == ADDR_TXDATA);
    assign wr_ctrl   = bus.iocs && !bus.iorw && (bus.ioaddr == ADDR_CTRL);
    assign last_stop = (state_q == STOP) && (stop_cnt_q == 1'(STOP_BITS - 1));
    // A new frame starts either from idle or straight out of the final stop bit.
    assign pop       = bus.brg_full && !fifo_empty && !brk_act &&
                       ((state_q == IDLE) || last_stop);
    assign overrun   = wr_data && fifo_full && !pop;
    assign par_bit_d = (^head) ^ (par_mode_q == PAR_ODD);

    spart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (wr_data),
        .push_dat_i (bus.databus),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .cnt_o      (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_mode_q <= PAR_NONE;
            ovr_q      <= 1'b0;
        end else if (wr_ctrl) begin
            par_mode_q <= bus.databus[1:0];
            ovr_q      <= 1'b0;
        end else if (overrun) begin
            ovr_q      <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            frm_par_q  <= PAR_NONE;
            par_bit_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else if (pop) begin
            state_q   <= START;
            shift_q   <= head;
            frm_par_q <= par_mode_q;
            par_bit_q <= par_bit_d;
            txd_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: txd_q <= !brk_act;
                START: if (bus.brg_full) begin
                    state_q   <= DATA;
                    bit_cnt_q <= '0;
                    txd_q     <= shift_q[0];
                    shift_q   <= shift_q >> 1;
                end
                DATA: if (bus.brg_full) begin
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        if (par_enabled(frm_par_q)) begin
                            state_q <= PARITY;
                            txd_q   <= par_bit_q;
                        end else begin
                            state_q    <= STOP;
                            stop_cnt_q <= 1'b0;
                            txd_q      <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        txd_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end
                end
                PARITY: if (bus.brg_full) begin
                    state_q    <= STOP;
                    stop_cnt_q <= 1'b0;
                    txd_q      <= 1'b1;
                end
                STOP: if (bus.brg_full) begin
                    if (last_stop) begin
                        state_q <= IDLE;
                        txd_q   <= !brk_act;
                    end else begin
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.txd      = txd_q;
    assign bus.tbr      = !fifo_full;
    assign bus.tx_busy  = (state_q != IDLE) || (fifo_cnt != '0);
    assign bus.fifo_cnt = fifo_cnt;
    assign bus.ovr      = ovr_q;

endmodule

// File: doc/tx_spart_fifo.md
Name: tx_spart_fifo

Overview:
Parametrised successor to the single-byte SPART transmitter. It accepts characters from the processor bus into a small FIFO and serialises each one on txd. Framing is configurable: 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits. It sits between the bus interface and the baud-rate generator, which supplies the brg_full one-cycle tick once per baud period.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; sets databus width.
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
iocs  in  1  chip select for bus accesses
iorw  in  1  0 = write, 1 = read
ioaddr  in  2  register select; 2'b00 = TX data, 2'b01 = control/status
databus  in  DATA_BITS  write data; bits [1:0] are control bits on an ioaddr 2'b01 write
brg_full  in  1  one-cycle baud tick
txd  out  1  serial output, idle high
tbr  out  1  FIFO not full (space available)
tx_busy  out  1  frame in progress or FIFO not empty
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
ovr  out  1  sticky overrun flag

Behaviour:
Reset values:
- txd=1, tbr=1, tx_busy=0, fifo_cnt=0, ovr=0.
- Control register par_mode=2'b00.
- FIFO pointers 0, state IDLE.
- Reset asserted mid-frame forces txd=1 immediately (asynchronous), aborts the frame and flushes the FIFO.

Write push:
- Condition: iocs=1, iorw=0, ioaddr=2'b00.
- Pushes databus when not full, one entry per asserted cycle.
- tbr and fifo_cnt update the cycle after the push.

Write to full FIFO:
- Data is dropped and ovr is set.
- ovr clears only on a control write (iocs=1, iorw=0, ioaddr=2'b01), which also loads par_mode=databus[1:0].
- par_mode encoding: 00 none, 01 even, 10 odd, 11 treated as none.

Frame start:
- In IDLE with FIFO non-empty and brg_full=1: pop the head and latch data, par_mode and parity (XOR of data bits, inverted for odd).
- Go to START; txd=0 from the next cycle.
- par_mode changes affect only frames popped afterwards.

Bit timing:
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
- Each brg_full tick ends the current bit; txd changes in the cycle after the tick.
- Every bit is exactly one baud period.
- DATA sends LSB first; a bit counter counts 0..DATA_BITS-1.
- PARITY is entered only when par_mode is 01 or 10.
- STOP holds txd=1 for STOP_BITS ticks.

Back-to-back frames:
- On the final stop tick, a non-empty FIFO pops the next entry in that same cycle and START follows directly, with no idle gap.
- An empty FIFO returns to IDLE.

Simultaneous events:
- Push and pop in the same cycle leave fifo_cnt unchanged.
- A push to a full FIFO coincident with a pop is accepted, not an overrun.
- A push into an empty FIFO on a brg_full cycle in IDLE is not popped until the next tick.

Flags:
- tx_busy = (state != IDLE) or (fifo_cnt != 0).
- Reads (iorw=1) have no side effects in this block.

Optional Feature:
TX_BREAK_EN.
- Defined: adds input port brk (1 bit).
  - While brk=1, txd is forced to 0 and the FSM holds in IDLE without popping.
  - Raising brk mid-frame waits until that frame's final stop bit completes.
  - Releasing brk returns txd to 1 on the next cycle.
  - A break length of at least one frame is the software's responsibility.
- Undefined: no brk port; behaviour exactly as above.

Decomposition:
Package tx_spart_pkg holds:
- State enum tx_state_t (IDLE, START, DATA, PARITY, STOP).
- par_mode localparams PAR_NONE, PAR_EVEN, PAR_ODD.
- Address constants ADDR_TXDATA=2'b00, ADDR_CTRL=2'b01.

Sub-module spart_fifo:
- Parameterised by width and depth.
- Push/pop/full/empty/count interface.
- Reused later by the receiver.

Test Plan:
1. DATA_BITS=8, par_mode=none, STOP_BITS=1, write 8'hA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit one tick; tx_busy falls after the stop bit.
2. par_mode=even, write 8'h07 -> parity bit 1; par_mode=odd, write 8'h07 -> parity bit 0; frame length 11 ticks.
3. Write 6 bytes back-to-back with FIFO_DEPTH=4 while idle, no ticks -> tbr=0 after the 4th write, ovr=1 after the 5th; the 4 queued bytes are sent back-to-back with no idle bits; ovr clears on a control write.
4. DATA_BITS=7, STOP_BITS=2, write 7'h41 -> 0,1,0,0,0,0,0,1,1,1 (10 ticks).
5. Assert rst low during the 3rd data bit -> txd=1 in the same cycle, fifo_cnt=0, tbr=1; a new write after release transmits normally.
6. TX_BREAK_EN defined, brk=1 mid-frame -> frame completes, then txd=0 while brk is held; on release txd=1 and queued data resumes.
